code_entry: RTL and testbench
=============================

# code_entry

Operator digit-entry stage upstream of the detonator control FSM. It takes the debounced `confirm` key and the 4-bit `A` switch value and accepts one BCD digit per confirm press, shifting it into a 16-bit code. When four digits have been accepted, it presents the code with a one-cycle `code_valid` pulse. It also rejects non-BCD digits, abandons a partial entry after an inactivity timeout, and drives the running code for display.

## Interface
- `TIMEOUT_MAX`, default 625_000_000: inactivity limit in clock cycles (5 s at 125 MHz); minimum 2.
- `DIGITS`, default 4: digits per code. Fixed at 4; code width is 4*DIGITS.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `entry_en`  in  1  level; entry permitted (driven by detonator FSM during setup/sure phases).
- `confirm`  in  1  debounced confirm key level; a rising edge accepts a digit.
- `clear`  in  1  debounced clear key level; a rising edge discards the partial code.
- `A`  in  4  digit value from switches.
- `code`  out  16  accumulated code; first digit ends up in [15:12].
- `digit_cnt`  out  3  digits accepted so far, 0..4.
- `code_valid`  out  1  one-cycle pulse when the 4th digit is accepted.
- `digit_err`  out  1  one-cycle pulse when a confirmed digit has A > 9.
- `timeout`  out  1  one-cycle pulse when a partial entry is abandoned.
- `busy`  out  1  high in ENTRY with digit_cnt ≥ 1.

## Operation
- Edge detection:
  - Registers `confirm_q` and `clear_q` reset to 1, so a key held through reset produces no edge.
  - `cf_edge = confirm & ~confirm_q`.
  - `cl_edge = clear & ~clear_q`.
  - The edge registers track the inputs in every state.
- States: IDLE, ENTRY, DONE. Reset state is IDLE.
- IDLE:
  - Holds code = 0 and digit_cnt = 0.
  - If entry_en = 1, go to ENTRY. Edges in IDLE are ignored.
- ENTRY, evaluated in priority order:
  1. entry_en = 0: clear code and count, go to IDLE.
  2. cl_edge: clear code and count, stay in ENTRY. Clear beats a simultaneous confirm.
  3. cf_edge with A > 9: pulse digit_err. Code, count and timer are unchanged.
  4. cf_edge with A ≤ 9: set code = {code[11:0], A}, increment digit_cnt, restart the timer. If this is the 4th digit, pulse code_valid and go to DONE.
  5. Timer reaches TIMEOUT_MAX-1 with digit_cnt ≥ 1: clear code and count, pulse timeout.
- DONE:
  - Holds code and digit_cnt = 4. Further confirm edges are ignored.
  - cl_edge: clear code and count, go to ENTRY.
  - entry_en = 0: clear code and count, go to IDLE.
- Timer:
  - Width is clog2(TIMEOUT_MAX).
  - Counts only in ENTRY with digit_cnt ≥ 1.
  - Held at 0 otherwise, and zeroed on any accepted digit, clear, or timeout.
- Arithmetic: digit_cnt saturates at 4. code never holds a non-BCD nibble.

## Timing
- Reset values: code = 0, digit_cnt = 0, all pulses = 0, busy = 0, state = IDLE.
- Digit latency: confirm is first sampled high at clock edge n. The new code and digit_cnt are visible after edge n, i.e. one cycle.
- code_valid is high in exactly the cycle in which code first shows all 4 digits.
- digit_err and timeout are single-cycle pulses, aligned the same way.
- entry_en rising: ENTRY after 1 cycle. A confirm edge on that same cycle is not captured.
- Timeout: fires TIMEOUT_MAX cycles after the last accepted digit, if no other event occurs.
- An asynchronous reset asserted mid-entry or in DONE returns every output to its reset value immediately, with no pulse emitted.

## Structure
- Shared header `detonator_defs.vh` holds:
  - the state encodings `ST_IDLE`, `ST_ENTRY`, `ST_DONE`;
  - `CODE_W = 16`;
  - `BCD_MAX = 4'd9`.
- One sub-module, `rise_detect`: a parameterised-reset-value edge detector, instantiated for confirm and for clear.
- Timer and FSM stay inline.

## Test plan
- Reset, then entry_en = 1. Confirm A = 2, 5, 8, 0 in turn → code = 16'h2580, digit_cnt = 4, code_valid is a single pulse coincident with code = 16'h2580, state DONE.
- Confirm A = 4'hB after one valid digit 7 → digit_err pulse; code stays 16'h0007; digit_cnt stays 1.
- Enter digits 1, 2, then clear and confirm rising on the same cycle → code = 0, digit_cnt = 0, no digit captured.
- With TIMEOUT_MAX = 16, enter digit 3 and idle → timeout pulse exactly 16 cycles after capture; code = 0; busy drops.
- Confirm held high through reset release, entry_en = 1 → no digit captured until confirm falls and rises again.
- In DONE, extra confirm edges → code unchanged. Drop entry_en → IDLE, code = 0. Assert rst mid-entry → all outputs 0 asynchronously.

Source files
------------

// File: rtl/code_entry_pkg.sv
// Shared types and constants for the operator code-entry stage.
package code_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          CODE_W  = 16;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/code_entry_if.sv
// Key/switch inputs and code/status outputs of the code-entry stage.
interface code_entry_if;
  import code_entry_pkg::*;

  logic              i_entry_en;
  logic              i_confirm;
  logic              i_clear;
  logic [3:0]        i_a;
  logic [CODE_W-1:0] o_code;
  logic [2:0]        o_digit_cnt;
  logic              o_code_valid;
  logic              o_digit_err;
  logic              o_timeout;
  logic              o_busy;

  modport slave (
    input  i_entry_en, i_confirm, i_clear, i_a,
    output o_code, o_digit_cnt, o_code_valid, o_digit_err, o_timeout, o_busy
  );

  modport master (
    output i_entry_en, i_confirm, i_clear, i_a,
    input  o_code, o_digit_cnt, o_code_valid, o_digit_err, o_timeout, o_busy
  );

endinterface

// File: rtl/code_entry_rise_detect.sv
// Rising-edge detector; reset value chosen so a level held through reset gives no edge.
module code_entry_rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RST_VAL;
    else        r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/code_entry.sv
// Operator digit entry: accepts BCD digits on confirm edges, assembles a 4-digit code.
// state | meaning: IDLE entry disabled | ENTRY collecting digits | DONE full code held
module code_entry
  import code_entry_pkg::*;
#(
  parameter int TIMEOUT_MAX = 625_000_000,
  parameter int DIGITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  code_entry_if.slave bus
);

  localparam int             TW         = $clog2(TIMEOUT_MAX);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_MAX - 1);
  localparam logic [2:0]     LAST_DIGIT = 3'(DIGITS - 1);

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [2:0]        r_cnt;
  logic [TW-1:0]     r_timer;
  logic              r_valid;
  logic              r_err;
  logic              r_to;
  logic              w_cf_edge;
  logic              w_cl_edge;

  code_entry_rise_detect #(.RST_VAL(1'b1)) u_cf_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.i_confirm),
    .o_rise (w_cf_edge)
  );

  code_entry_rise_detect #(.RST_VAL(1'b1)) u_cl_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.i_clear),
    .o_rise (w_cl_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_code  <= '0;
          r_cnt   <= '0;
          r_timer <= '0;
          if (bus.i_entry_en) r_state <= ST_ENTRY;
        end
        ST_ENTRY: begin
          if (!bus.i_entry_en) begin
            r_code  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else if (w_cl_edge) begin
            r_code  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
          end else if (w_cf_edge && !is_bcd(bus.i_a)) begin
            r_err <= 1'b1;
          end else if (w_cf_edge) begin
            r_code  <= {r_code[CODE_W-5:0], bus.i_a};
            r_cnt   <= r_cnt + 3'd1;
            r_timer <= '0;
            if (r_cnt == LAST_DIGIT) begin
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (r_cnt != 3'd0) begin
            // Abandon a partial code once the operator has been idle too long.
            if (r_timer == TIMER_LAST) begin
              r_code  <= '0;
              r_cnt   <= '0;
              r_timer <= '0;
              r_to    <= 1'b1;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        ST_DONE: begin
          r_timer <= '0;
          if (!bus.i_entry_en) begin
            r_code  <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (w_cl_edge) begin
            r_code  <= '0;
            r_cnt   <= '0;
            r_state <= ST_ENTRY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_code       = r_code;
  assign bus.o_digit_cnt  = r_cnt;
  assign bus.o_code_valid = r_valid;
  assign bus.o_digit_err  = r_err;
  assign bus.o_timeout    = r_to;
  assign bus.o_busy       = (r_state == ST_ENTRY) && (r_cnt != 3'd0);

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed vector table, corner sequences, random vs model.
module tb_code_entry;
  import code_entry_pkg::*;

  localparam int TMAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  code_entry_if bus();

  code_entry #(.TIMEOUT_MAX(TMAX), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle / 1 collecting / 2 full code held
  int          m_mode;
  int unsigned m_dig[$];
  int          m_since;
  logic        m_cf_prev, m_cl_prev;
  logic        m_valid, m_err, m_to;

  typedef struct {
    logic        en, cf, cl;
    logic [3:0]  a;
    logic [15:0] code;
    logic [2:0]  cnt;
    logic        valid, err, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] m_code();
    logic [15:0] c = 16'h0;
    foreach (m_dig[i]) c = (c << 4) | 16'(m_dig[i]);
    return c;
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_dig.delete();
    m_since = 0;
    m_cf_prev = 1'b1;
    m_cl_prev = 1'b1;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_to = 1'b0;
  endtask

  task automatic m_step();
    logic cf, cl;
    cf = bus.i_confirm & ~m_cf_prev;
    cl = bus.i_clear & ~m_cl_prev;
    m_cf_prev = bus.i_confirm;
    m_cl_prev = bus.i_clear;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_to = 1'b0;
    case (m_mode)
      0: if (bus.i_entry_en) m_mode = 1;
      1: begin
        if (!bus.i_entry_en) begin
          m_dig.delete(); m_since = 0; m_mode = 0;
        end else if (cl) begin
          m_dig.delete(); m_since = 0;
        end else if (cf && bus.i_a > 4'd9) begin
          m_err = 1'b1;
        end else if (cf) begin
          m_dig.push_back(int'(bus.i_a));
          m_since = 0;
          if (m_dig.size() == 4) begin m_valid = 1'b1; m_mode = 2; end
        end else if (m_dig.size() > 0) begin
          m_since++;
          if (m_since == TMAX) begin
            m_dig.delete(); m_since = 0; m_to = 1'b1;
          end
        end
      end
      default: begin
        if (!bus.i_entry_en) begin m_dig.delete(); m_mode = 0; end
        else if (cl) begin m_dig.delete(); m_mode = 1; end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".code"},  32'(bus.o_code),       32'(m_code()));
    chk({tag, ".cnt"},   32'(bus.o_digit_cnt),  32'(m_dig.size()));
    chk({tag, ".valid"}, 32'(bus.o_code_valid), 32'(m_valid));
    chk({tag, ".err"},   32'(bus.o_digit_err),  32'(m_err));
    chk({tag, ".tmo"},   32'(bus.o_timeout),    32'(m_to));
    chk({tag, ".busy"},  32'(bus.o_busy),       32'((m_mode == 1) && (m_dig.size() > 0)));
  endtask

  task automatic drive(input logic en, input logic cf, input logic cl, input logic [3:0] a);
    bus.i_entry_en = en;
    bus.i_confirm  = cf;
    bus.i_clear    = cl;
    bus.i_a        = a;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic add(input logic en, cf, cl, input logic [3:0] a, input logic [15:0] code,
                     input logic [2:0] cnt, input logic valid, err, busy);
    vec_t v;
    v.en = en; v.cf = cf; v.cl = cl; v.a = a;
    v.code = code; v.cnt = cnt; v.valid = valid; v.err = err; v.busy = busy;
    tbl.push_back(v);
  endtask

  initial begin
    int quiet;
    logic cf_r;
    logic [3:0] seq [4];

    add(1,0,0,4'h0, 16'h0000,0,0,0,0);
    add(1,1,0,4'h2, 16'h0002,1,0,0,1);
    add(1,0,0,4'h0, 16'h0002,1,0,0,1);
    add(1,1,0,4'h5, 16'h0025,2,0,0,1);
    add(1,0,0,4'h0, 16'h0025,2,0,0,1);
    add(1,1,0,4'h8, 16'h0258,3,0,0,1);
    add(1,0,0,4'h0, 16'h0258,3,0,0,1);
    add(1,1,0,4'h0, 16'h2580,4,1,0,0);
    add(1,0,0,4'h0, 16'h2580,4,0,0,0);
    add(1,1,0,4'h3, 16'h2580,4,0,0,0);
    add(1,0,0,4'h0, 16'h2580,4,0,0,0);
    add(1,0,1,4'h0, 16'h0000,0,0,0,0);
    add(1,1,0,4'h7, 16'h0007,1,0,0,1);
    add(1,0,0,4'h0, 16'h0007,1,0,0,1);
    add(1,1,0,4'hB, 16'h0007,1,0,1,1);
    add(1,0,0,4'h0, 16'h0007,1,0,0,1);
    add(1,1,0,4'h2, 16'h0072,2,0,0,1);
    add(1,0,0,4'h0, 16'h0072,2,0,0,1);
    add(1,1,1,4'h9, 16'h0000,0,0,0,0);
    add(1,0,0,4'h0, 16'h0000,0,0,0,0);
    add(1,1,0,4'h3, 16'h0003,1,0,0,1);

    drive(0, 0, 0, 4'h0);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst.code",  32'(bus.o_code), 32'h0);
    chk("rst.cnt",   32'(bus.o_digit_cnt), 32'h0);
    chk("rst.pulse", 32'({bus.o_code_valid, bus.o_digit_err, bus.o_timeout}), 32'h0);
    chk("rst.busy",  32'(bus.o_busy), 32'h0);
    rst_n = 1'b1;
    cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].cf, tbl[i].cl, tbl[i].a);
      cycle();
      chk($sformatf("vec%0d.code", i),  32'(bus.o_code),       32'(tbl[i].code));
      chk($sformatf("vec%0d.cnt", i),   32'(bus.o_digit_cnt),  32'(tbl[i].cnt));
      chk($sformatf("vec%0d.valid", i), 32'(bus.o_code_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d.err", i),   32'(bus.o_digit_err),  32'(tbl[i].err));
      chk($sformatf("vec%0d.busy", i),  32'(bus.o_busy),       32'(tbl[i].busy));
    end

    // Digit 3 captured on the last vector; timeout lands exactly TMAX cycles later
    drive(1, 0, 0, 4'h0);
    for (int k = 1; k < TMAX; k++) begin
      cycle();
      chk($sformatf("tmo.wait%0d", k), 32'({bus.o_timeout, bus.o_busy, bus.o_code}), {15'h0, 1'b0, 1'b1, 16'h0003});
    end
    cycle();
    chk("tmo.fire", 32'({bus.o_timeout, bus.o_busy, bus.o_code}), {15'h0, 1'b1, 1'b0, 16'h0000});
    chk("tmo.cnt",  32'(bus.o_digit_cnt), 32'h0);
    cycle();
    chk("tmo.single", 32'(bus.o_timeout), 32'h0);

    // Full code, then drop entry_en from DONE
    seq = '{4'h1, 4'h9, 4'h9, 4'h4};
    foreach (seq[i]) begin
      drive(1, 1, 0, seq[i]); cycle();
      drive(1, 0, 0, 4'h0);   cycle();
    end
    chk("done.code", 32'(bus.o_code), 32'h1994);
    drive(0, 0, 0, 4'h0); cycle();
    chk("idle.code", 32'({bus.o_digit_cnt, bus.o_code}), 32'h0);
    drive(1, 1, 0, 4'h5); cycle();
    chk("en_rise.nocap", 32'({bus.o_digit_cnt, bus.o_code}), 32'h0);
    drive(1, 0, 0, 4'h0); cycle();
    drive(1, 1, 0, 4'h5); cycle();
    chk("en_rise.cap", 32'({bus.o_digit_cnt, bus.o_code}), {13'h0, 3'd1, 16'h0005});

    // Asynchronous reset mid-entry clears outputs before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst.code", 32'(bus.o_code), 32'h0);
    chk("arst.cnt",  32'(bus.o_digit_cnt), 32'h0);
    chk("arst.busy", 32'({bus.o_busy, bus.o_code_valid, bus.o_digit_err, bus.o_timeout}), 32'h0);
    m_reset();
    drive(0, 1, 0, 4'h4);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Confirm held through reset release must not register as an edge
    drive(1, 1, 0, 4'h4);
    repeat (3) cycle();
    chk("held.nocap", 32'(bus.o_digit_cnt), 32'h0);
    drive(1, 0, 0, 4'h4); cycle();
    drive(1, 1, 0, 4'h6); cycle();
    chk("held.recap", 32'({bus.o_digit_cnt, bus.o_code}), {13'h0, 3'd1, 16'h0006});

    // Random traffic against the reference model
    quiet = 0;
    cf_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic en_r, cl_r;
      en_r = ($urandom_range(0, 39) != 0);
      cl_r = ($urandom_range(0, 29) == 0);
      if (quiet > 0) begin
        quiet--;
        cf_r = 1'b0;
      end else begin
        if ($urandom_range(0, 60) == 0) quiet = TMAX + 4;
        if ($urandom_range(0, 2) == 0) cf_r = ~cf_r;
      end
      drive(en_r, cf_r, cl_r, 4'($urandom_range(0, 15)));
      cycle();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
